// File: rtl/seq_add_sub_pkg.sv
// rtl/seq_add_sub_pkg.sv - shared types and helpers for the sequential adder/subtractor
//
// Purpose : FSM state encoding and the chunk-counter width helper used by
//           seq_add_sub.
package seq_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for NCH chunks: ceil(log2(nch)), never narrower than 1 bit
  // so that the single-chunk configuration still has a legal counter.
  function automatic int cnt_width(input int nch);
    if (nch <= 1) return 1;
    return $clog2(nch);
  endfunction

endpackage

// File: rtl/seq_add_sub_rca_chunk.sv
// rtl/seq_add_sub_rca_chunk.sv - K-bit ripple-carry chunk adder and its full-adder cell
//
// Purpose : combinational K-bit ripple adder reused once per clock by
//           seq_add_sub.
// Ports   : full_adder - a, b, cin in; sum, cout out
//           rca_chunk  - cout, sum[K-1:0] out; a[K-1:0], b[K-1:0], cin in
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_chunk #(
  parameter int K = 4
) (
  output logic         cout,
  output logic [K-1:0] sum,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin
);

  logic [K:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < K; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[K];

endmodule

// File: rtl/seq_add_sub.sv
// rtl/seq_add_sub.sv - multi-cycle N-bit adder/subtractor processing K bits per clock
//
// Purpose : adds or subtracts two N-bit operands one K-bit chunk per cycle,
//           with valid/ready handshakes on both sides.
// Ports   : clk, rst_n (async, active low)
//           in_valid, in_ready, a[N-1:0], b[N-1:0], sub   - operand side
//           out_valid, out_ready, sum[N-1:0], cout, ovf, zero - result side
// Config  : define SEQ_ADD_SUB_SAT_EN to saturate the sum on signed overflow;
//           left undefined, the result wraps around.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NCH = N / K;
  localparam int CW  = cnt_width(NCH);

  if ((K < 1) || (K > N) || ((N % K) != 0)) begin : g_param_err
    $error("seq_add_sub: N must be a positive multiple of K with 1 <= K <= N");
  end

  state_t         state, state_nx;
  logic [N-1:0]   a_r, b_r;
  logic           carry;
  logic [CW-1:0]  idx;
  logic [N-1:0]   sum_r;
  logic           cout_r, ovf_r, zero_r;

  logic [K-1:0]   ch_a, ch_b, ch_sum;
  logic           ch_cout;
  logic           last;
  logic [N-1:0]   sum_full, sum_fin;
  logic           ovf_nx;

  assign ch_a = a_r[idx*K +: K];
  assign ch_b = b_r[idx*K +: K];
  assign last = (idx == CW'(NCH - 1));

  rca_chunk #(.K(K)) u_chunk (
    .cout (ch_cout),
    .sum  (ch_sum),
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry)
  );

  // Sum as it will look once the current chunk is written; on the last chunk
  // this is the complete result the flags are derived from.
  always_comb begin
    sum_full = sum_r;
    sum_full[idx*K +: K] = ch_sum;
  end

  // b_r already holds ~b for subtraction, so one rule covers both modes.
  assign ovf_nx = (a_r[N-1] == b_r[N-1]) && (sum_full[N-1] != a_r[N-1]);

`ifdef SEQ_ADD_SUB_SAT_EN
  always_comb begin
    sum_fin = sum_full;
    if (ovf_nx) sum_fin = a_r[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
`else
  assign sum_fin = sum_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
          end
        end
        BUSY: begin
          carry <= ch_cout;
          if (last) begin
            sum_r  <= sum_fin;
            cout_r <= ch_cout;
            ovf_r  <= ovf_nx;
            zero_r <= (sum_fin == '0);
          end else begin
            sum_r <= sum_full;
            idx   <= idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
  assign zero = zero_r;

endmodule

// File: tb/tb_seq_add_sub.sv
// tb/tb_seq_add_sub.sv - self-checking bench for seq_add_sub across four N/K configurations
module tb_seq_add_sub;

  localparam int NI = 4;
  localparam int WN [NI] = '{8, 8, 16, 32};
  localparam int KK [NI] = '{4, 8, 1, 8};

  logic        clk;
  logic        rst_n;
  logic        iv  [NI];
  logic        orr [NI];
  logic        sb  [NI];
  logic [31:0] aa  [NI];
  logic [31:0] bb  [NI];
  logic        ir  [NI];
  logic        ov  [NI];
  logic        co  [NI];
  logic        of  [NI];
  logic        zr  [NI];
  logic [31:0] ss  [NI];
  logic [7:0]  s0, s1;
  logic [15:0] s2;
  logic [31:0] s3;

  int nvec = 0;
  int nerr = 0;

  assign ss[0] = {24'h0, s0};
  assign ss[1] = {24'h0, s1};
  assign ss[2] = {16'h0, s2};
  assign ss[3] = s3;

  seq_add_sub #(.N(8), .K(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(aa[0][7:0]), .b(bb[0][7:0]), .sub(sb[0]), .out_valid(ov[0]),
    .out_ready(orr[0]), .sum(s0), .cout(co[0]), .ovf(of[0]), .zero(zr[0]));

  seq_add_sub #(.N(8), .K(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(aa[1][7:0]), .b(bb[1][7:0]), .sub(sb[1]), .out_valid(ov[1]),
    .out_ready(orr[1]), .sum(s1), .cout(co[1]), .ovf(of[1]), .zero(zr[1]));

  seq_add_sub #(.N(16), .K(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(aa[2][15:0]), .b(bb[2][15:0]), .sub(sb[2]), .out_valid(ov[2]),
    .out_ready(orr[2]), .sum(s2), .cout(co[2]), .ovf(of[2]), .zero(zr[2]));

  seq_add_sub #(.N(32), .K(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .a(aa[3]), .b(bb[3]), .sub(sb[3]), .out_valid(ov[3]),
    .out_ready(orr[3]), .sum(s3), .cout(co[3]), .ovf(of[3]), .zero(zr[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  task automatic model(input int n, input logic [31:0] a, input logic [31:0] b, input bit sub,
                       output logic [31:0] s, output bit c, output bit o, output bit z);
    longint mask, half, ua, ub, sa, sbv, r, raw;
    mask = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sbv  = (ub >= half) ? ub - (mask + 1) : ub;
    r    = sub ? sa - sbv : sa + sbv;
    raw  = sub ? ua - ub : ua + ub;
    c    = sub ? (ua >= ub) : (ua + ub > mask);
    o    = (r > half - 1) || (r < -half);
    s    = 32'(raw & mask);
`ifdef SEQ_ADD_SUB_SAT_EN
    if (o) s = (r > 0) ? 32'(half - 1) : 32'(half);
`endif
    z = (s == 0);
  endtask

  // Present one operand set, wait for the result, capture it and release it.
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b, input bit sub,
                       output logic [31:0] s, output bit c, output bit o, output bit z);
    int lat;
    @(negedge clk);
    aa[k] = a; bb[k] = b; sb[k] = sub; iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    aa[k] = $urandom; bb[k] = $urandom; sb[k] = ~sub;
    lat = 1;
    while (!ov[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency inst%0d", k), lat, WN[k] / KK[k] + 1);
    s = ss[k]; c = co[k]; o = of[k]; z = zr[k];
    orr[k] = 1'b1;
    @(negedge clk);
    orr[k] = 1'b0;
    chk($sformatf("release inst%0d {out_valid,in_ready}", k), {ov[k], ir[k]}, 2'b01);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         sub;
    logic [7:0] s;
    bit         c;
    bit         o;
    bit         z;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] rs, es, hold, a, b, mask;
    bit rc, ro, rz, ec, eo, ez, sub, seen;

    tbl[0] = '{8'hF0, 8'hF0, 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
`ifdef SEQ_ADD_SUB_SAT_EN
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
`else
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
`endif

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b0; sb[k] = 1'b0; aa[k] = '0; bb[k] = '0;
    end
    repeat (2) @(negedge clk);

    chk("reset in_ready", ir[0], 1'b1);
    chk("reset out_valid", ov[0], 1'b0);
    chk("reset sum", ss[0], 32'h0);
    chk("reset {cout,ovf,zero}", {co[0], of[0], zr[0]}, 3'b001);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(0, 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].sub, rs, rc, ro, rz);
      chk($sformatf("tbl%0d sum", i), rs, 32'(tbl[i].s));
      chk($sformatf("tbl%0d {cout,ovf,zero}", i), {rc, ro, rz}, {tbl[i].c, tbl[i].o, tbl[i].z});
    end

    // Backpressure: result must hold while the consumer stalls.
    @(negedge clk);
    aa[0] = 32'h12; bb[0] = 32'h34; sb[0] = 1'b0; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    for (int t = 0; t < 50 && !ov[0]; t++) @(negedge clk);
    hold = ss[0];
    chk("bp sum", hold, 32'h46);
    for (int t = 0; t < 5; t++) begin
      iv[0] = 1'b1; aa[0] = $urandom; bb[0] = $urandom; sb[0] = $urandom;
      @(negedge clk);
      chk($sformatf("bp hold%0d {out_valid,in_ready}", t), {ov[0], ir[0]}, 2'b10);
      chk($sformatf("bp hold%0d sum", t), ss[0], hold);
    end
    iv[0] = 1'b0; orr[0] = 1'b1;
    @(negedge clk);
    orr[0] = 1'b0;
    chk("bp release {out_valid,in_ready}", {ov[0], ir[0]}, 2'b01);
    chk("bp sum held in idle", ss[0], 32'h46);
    do_op(0, 32'h21, 32'h09, 1'b1, rs, rc, ro, rz);
    chk("bp next op sum", rs, 32'h18);

    // Reset during the first BUSY cycle aborts the operation.
    @(negedge clk);
    aa[0] = 32'h55; bb[0] = 32'h22; sb[0] = 1'b0; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort {out_valid,in_ready}", {ov[0], ir[0]}, 2'b01);
    chk("abort sum", ss[0], 32'h0);
    chk("abort {cout,ovf,zero}", {co[0], of[0], zr[0]}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    chk("abort no out_valid", seen, 1'b0);

    // Random sweep against the reference model.
    for (int k = 0; k < NI; k++) begin
      mask = (WN[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WN[k]) - 1);
      for (int i = 0; i < ((k == 0) ? 200 : 1000); i++) begin
        case ($urandom_range(0, 5))
          0:       a = 32'h0;
          1:       a = mask;
          2:       a = 32'd1 << (WN[k] - 1);
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 5))
          0:       b = 32'h0;
          1:       b = mask;
          2:       b = (32'd1 << (WN[k] - 1)) - 1;
          3:       b = a;
          default: b = $urandom;
        endcase
        a = a & mask;
        b = b & mask;
        sub = $urandom_range(0, 1);
        do_op(k, a, b, sub, rs, rc, ro, rz);
        model(WN[k], a, b, sub, es, ec, eo, ez);
        chk($sformatf("rand inst%0d op%0d a=%0h b=%0h sub=%0d sum", k, i, a, b, sub), rs, es);
        chk($sformatf("rand inst%0d op%0d a=%0h b=%0h sub=%0d flags", k, i, a, b, sub),
            {rc, ro, rz}, {ec, eo, ez});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
